// File: rtl/switch_out_arbiter_if.sv
// Handshake bundle between the four input-FIFO heads and one output port.
// Carries the per-source request/last/data heads, the pop strobes back to
// the FIFOs, and the registered output beat with its ready signal.
//   master : arbiter side  - samples req/last/data_in/out_ready, drives pop/out_*
//   slave  : environment   - drives req/last/data_in/out_ready, samples pop/out_*
interface switch_out_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_SRC-1:0]        req;
  logic [NUM_SRC-1:0]        last;
  logic [NUM_SRC*DATA_W-1:0] data_in;
  logic [NUM_SRC-1:0]        pop;
  logic                      out_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic                      out_last;

  modport master (
    input  req, last, data_in, out_ready,
    output pop, out_valid, out_data, out_last
  );

  modport slave (
    output req, last, data_in, out_ready,
    input  pop, out_valid, out_data, out_last
  );
endinterface

// File: rtl/switch_out_arbiter.sv
// Per-output-port packet scheduler: round-robin over NUM_SRC FIFO heads, packet-granular lock.
// Latency: grant 1 cycle after req in IDLE; a popped beat appears on out_* 1 cycle after its pop.
// Backpressure: pop is combinational on out_ready; no internal beat storage, stalls hold the lock.
//
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   bus (master) : req/last/data_in heads in, pop strobes out, registered out_valid/out_data/out_last
//   grant        : registered one-hot owner, 0 when idle
//   abort        : one-cycle pulse when the stall watchdog releases the owner
//   pkt_count    : completed packets (wrapping), abort_count : watchdog releases (saturating)
module switch_out_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  switch_out_arbiter_if.master bus,
  output logic [NUM_SRC-1:0]   grant,
  output logic                 abort,
  output logic [15:0]          pkt_count,
  output logic [7:0]           abort_count
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [NUM_SRC-1:0] grant_d;
  logic [7:0]         idle_cnt_q, idle_cnt_d;
  logic               valid_q, valid_d;
  beat_t              beat_q, beat_d;
  logic               abort_d;
  logic [15:0]        pkt_cnt_d;
  logic [7:0]         abort_cnt_d;
  logic [NUM_SRC-1:0] pop_c;

  // Round-robin search: first requester at or after rr_ptr, wrapping.
  logic               found;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   scan;

  always_comb begin
    found  = 1'b0;
    winner = rr_ptr_q;
    scan   = rr_ptr_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      scan = IDX_W'((int'(rr_ptr_q) + i) % NUM_SRC);
      if (!found && bus.req[scan]) begin
        found  = 1'b1;
        winner = scan;
      end
    end
  end

  // Head of the current owner's FIFO.
  logic              owner_req;
  logic              owner_last;
  logic [DATA_W-1:0] owner_data;
  logic [IDX_W-1:0]  next_ptr;

  assign owner_req  = bus.req[owner_q];
  assign owner_last = bus.last[owner_q];
  assign owner_data = bus.data_in[int'(owner_q)*DATA_W +: DATA_W];
  // After a release the search starts just past the released owner.
  assign next_ptr   = (int'(owner_q) == NUM_SRC-1) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    grant_d     = grant;
    idle_cnt_d  = idle_cnt_q;
    valid_d     = 1'b0;
    beat_d      = beat_q;
    abort_d     = 1'b0;
    pkt_cnt_d   = pkt_count;
    abort_cnt_d = abort_count;
    pop_c       = '0;

    case (state_q)
      IDLE: begin
        // Arbitration cycle moves no data: at least one bubble between packets.
        idle_cnt_d = '0;
        if (found) begin
          state_d = BUSY;
          owner_d = winner;
          grant_d = NUM_SRC'(1) << winner;
        end
      end

      BUSY: begin
        pop_c = grant & bus.req & {NUM_SRC{bus.out_ready}};
        if (owner_req) begin
          // A present-but-blocked head is backpressure, not starvation.
          idle_cnt_d = '0;
          if (bus.out_ready) begin
            valid_d = 1'b1;
            beat_d  = '{last: owner_last, data: owner_data};
            if (owner_last) begin
              state_d   = IDLE;
              grant_d   = '0;
              rr_ptr_d  = next_ptr;
              pkt_cnt_d = pkt_count + 16'd1;
            end
          end
        end else if (idle_cnt_q == 8'(TIMEOUT - 1)) begin
          // This cycle is the TIMEOUT-th consecutive one without a head: release.
          state_d    = IDLE;
          grant_d    = '0;
          rr_ptr_d   = next_ptr;
          idle_cnt_d = '0;
          abort_d    = 1'b1;
          if (abort_count != 8'hFF) begin
            abort_cnt_d = abort_count + 8'd1;
          end
        end else begin
          idle_cnt_d = idle_cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // No FIFO may lose a beat while the arbiter is being reset.
  assign bus.pop = rst_n ? pop_c : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      grant       <= '0;
      idle_cnt_q  <= '0;
      valid_q     <= 1'b0;
      beat_q      <= '0;
      abort       <= 1'b0;
      pkt_count   <= '0;
      abort_count <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      grant       <= grant_d;
      idle_cnt_q  <= idle_cnt_d;
      valid_q     <= valid_d;
      beat_q      <= beat_d;
      abort       <= abort_d;
      pkt_count   <= pkt_cnt_d;
      abort_count <= abort_cnt_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = beat_q.data;
  assign bus.out_last  = beat_q.last;

endmodule

// File: tb/tb_switch_out_arbiter.sv
// Bench for switch_out_arbiter: FIFO-queue sources, a packet-level reference
// model checked every cycle, and literal expectations per scenario.
module tb_switch_out_arbiter;
  localparam int NUM_SRC = 4;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  grant;
  logic        abort;
  logic [15:0] pkt_count;
  logic [7:0]  abort_count;

  switch_out_arbiter_if #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W)) bus ();

  switch_out_arbiter #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .grant       (grant),
    .abort       (abort),
    .pkt_count   (pkt_count),
    .abort_count (abort_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pops_total = 0;
  logic chk_en = 1'b0;
  logic [3:0] pop_seen = '0;
  logic [3:0] en;

  // Source FIFOs: {last, data}
  logic [8:0] q [NUM_SRC][$];

  // Observation logs
  logic [7:0] lg_data [$];
  logic       lg_last [$];
  int         lg_cyc  [$];
  int         pl_cnt  [$];
  logic [3:0] gl_val  [$];
  int         gl_cyc  [$];
  int         ab_cyc  [$];
  logic [3:0] ab_grant[$];
  int         ab_cnt  [$];
  logic [3:0] prev_grant = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (packet-level view) ----------------
  int   m_owner, m_ptr, m_starve, m_pkts, m_aborts, m_s;
  logic e_valid, e_last, e_abort;
  logic [7:0] e_data;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_starve = 0; m_pkts = 0; m_aborts = 0;
      e_valid = 1'b0; e_data = '0; e_last = 1'b0; e_abort = 1'b0;
    end else begin
      e_valid = 1'b0;
      e_abort = 1'b0;
      if (m_owner < 0) begin
        for (int k = 0; k < NUM_SRC; k++) begin
          m_s = (m_ptr + k) % NUM_SRC;
          if (m_owner < 0 && bus.req[m_s]) m_owner = m_s;
        end
        m_starve = 0;
      end else if (bus.req[m_owner]) begin
        m_starve = 0;
        if (bus.out_ready) begin
          e_valid = 1'b1;
          e_data  = bus.data_in[m_owner*DATA_W +: DATA_W];
          e_last  = bus.last[m_owner];
          if (e_last) begin
            m_pkts  = (m_pkts + 1) % 65536;
            m_ptr   = (m_owner + 1) % NUM_SRC;
            m_owner = -1;
          end
        end
      end else begin
        m_starve++;
        if (m_starve >= TIMEOUT) begin
          e_abort = 1'b1;
          if (m_aborts < 255) m_aborts++;
          m_ptr    = (m_owner + 1) % NUM_SRC;
          m_owner  = -1;
          m_starve = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare + logging ----------------
  logic [3:0] exp_pop, exp_grant;
  always @(negedge clk) begin
    if (chk_en) begin
      exp_pop = '0;
      if (rst_n && m_owner >= 0 && bus.req[m_owner] && bus.out_ready) exp_pop[m_owner] = 1'b1;
      exp_grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
      check("pop", int'(bus.pop), int'(exp_pop));
      check("grant", int'(grant), int'(exp_grant));
      check("out_valid", int'(bus.out_valid), int'(e_valid));
      if (e_valid) begin
        check("out_data", int'(bus.out_data), int'(e_data));
        check("out_last", int'(bus.out_last), int'(e_last));
      end
      check("abort", int'(abort), int'(e_abort));
      check("pkt_count", int'(pkt_count), m_pkts);
      check("abort_count", int'(abort_count), m_aborts);

      pop_seen = bus.pop;
      if (bus.out_valid) begin
        lg_data.push_back(bus.out_data);
        lg_last.push_back(bus.out_last);
        lg_cyc.push_back(cyc);
        if (bus.out_last) pl_cnt.push_back(int'(pkt_count));
      end
      if (grant != prev_grant && grant != 4'd0) begin
        gl_val.push_back(grant);
        gl_cyc.push_back(cyc);
      end
      prev_grant = grant;
      if (abort) begin
        ab_cyc.push_back(cyc);
        ab_grant.push_back(grant);
        ab_cnt.push_back(int'(abort_count));
      end
    end
  end

  // Bounds-safe log readers
  function automatic int lgd(input int i);
    if (i >= 0 && i < lg_data.size()) return int'(lg_data[i]);
    return -1;
  endfunction
  function automatic int lgl(input int i);
    if (i >= 0 && i < lg_last.size()) return int'(lg_last[i]);
    return -1;
  endfunction
  function automatic int lgc(input int i);
    if (i >= 0 && i < lg_cyc.size()) return lg_cyc[i];
    return -1000;
  endfunction
  function automatic int glv(input int i);
    if (i >= 0 && i < gl_val.size()) return int'(gl_val[i]);
    return -1;
  endfunction
  function automatic int glc(input int i);
    if (i >= 0 && i < gl_cyc.size()) return gl_cyc[i];
    return -1000;
  endfunction

  // ---------------- source driver ----------------
  task automatic push(input int s, input logic lst, input logic [7:0] d);
    q[s].push_back({lst, d});
  endtask

  task automatic refresh();
    logic [8:0] h;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (q[s].size() > 0 && en[s]) begin
        h = q[s][0];
        bus.req[s] = 1'b1;
        bus.last[s] = h[8];
        bus.data_in[s*DATA_W +: DATA_W] = h[7:0];
      end else begin
        bus.req[s] = 1'b0;
        bus.last[s] = 1'b0;
        bus.data_in[s*DATA_W +: DATA_W] = '0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (pop_seen[s] && q[s].size() > 0) begin
        void'(q[s].pop_front());
        pops_total++;
      end
    end
    refresh();
  endtask

  function automatic int pending();
    int p;
    p = 0;
    for (int s = 0; s < NUM_SRC; s++) if (en[s]) p += q[s].size();
    return p;
  endfunction

  task automatic drain(input string name);
    int n;
    n = 0;
    while (pending() > 0 && n < 150) begin
      step();
      n++;
    end
    check(name, pending(), 0);
    repeat (3) step();
  endtask

  int b, g, a, t0, pt, drop, n;

  initial begin
    rst_n = 1'b0;
    bus.req = '0; bus.last = '0; bus.data_in = '0; bus.out_ready = 1'b1;
    en = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_grant", int'(grant), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_data", int'(bus.out_data), 0);
    check("rst_abort", int'(abort), 0);
    check("rst_pkt_count", int'(pkt_count), 0);
    check("rst_abort_count", int'(abort_count), 0);
    rst_n = 1'b1;

    // Single source, 3-beat packet
    b = lg_data.size(); g = gl_val.size(); t0 = cyc;
    push(0, 1'b0, 8'hA1); push(0, 1'b0, 8'hA2); push(0, 1'b1, 8'hA3);
    refresh();
    drain("t1_drain");
    check("t1_grant_val", glv(g), 1);
    check("t1_grant_cyc", glc(g) - t0, 1);
    check("t1_beats", lg_data.size() - b, 3);
    check("t1_d0", lgd(b), 8'hA1);
    check("t1_d1", lgd(b+1), 8'hA2);
    check("t1_d2", lgd(b+2), 8'hA3);
    check("t1_l1", lgl(b+1), 0);
    check("t1_l2", lgl(b+2), 1);
    check("t1_cyc0", lgc(b) - t0, 2);
    check("t1_cyc2", lgc(b+2) - t0, 4);
    check("t1_pkts", int'(pkt_count), 1);
    check("t1_grant_end", int'(grant), 0);

    // rr_ptr is now 1: source 1 beats source 0
    b = lg_data.size();
    push(0, 1'b1, 8'hB0); push(1, 1'b1, 8'hB1);
    refresh();
    drain("ptr_drain");
    check("ptr_first", lgd(b), 8'hB1);
    check("ptr_second", lgd(b+1), 8'hB0);

    // Fairness after reset: two 2-beat packets per source
    rst_n = 1'b0; step(); rst_n = 1'b1;
    b = lg_data.size(); g = gl_val.size(); a = pl_cnt.size();
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < NUM_SRC; s++) begin
        push(s, 1'b0, 8'(8'h40 + s*8 + p*2));
        push(s, 1'b1, 8'(8'h40 + s*8 + p*2 + 1));
      end
    refresh();
    drain("fair_drain");
    for (int k = 0; k < 8; k++) check("fair_grant_order", glv(g+k), 1 << (k % 4));
    for (int j = 0; j < 16; j++)
      check("fair_data", lgd(b+j), 8'h40 + ((j/2) % 4)*8 + ((j/2)/4)*2 + (j % 2));
    for (int k = 0; k < 7; k++) check("fair_gap", lgc(b+2*k+2) - lgc(b+2*k+1), 2);
    check("fair_pkts_at_5", (a+4 < pl_cnt.size()) ? pl_cnt[a+4] : -1, 5);

    // Backpressure on owner 2 mid-packet
    b = lg_data.size();
    push(2, 1'b0, 8'hC0); push(2, 1'b0, 8'hC1); push(2, 1'b0, 8'hC2); push(2, 1'b1, 8'hC3);
    refresh();
    n = 0;
    while (q[2].size() > 2 && n < 30) begin step(); n++; end
    check("bp_reach", q[2].size(), 2);
    pt = pops_total;
    bus.out_ready = 1'b0;
    repeat (20) step();
    check("bp_stall_pops", pops_total - pt, 0);
    check("bp_beats_in_stall", lg_data.size() - b, 2);
    check("bp_no_abort", int'(abort_count), 0);
    bus.out_ready = 1'b1;
    drain("bp_drain");
    check("bp_beats", lg_data.size() - b, 4);
    for (int j = 0; j < 4; j++) begin
      check("bp_data", lgd(b+j), 8'hC0 + j);
      check("bp_last", lgl(b+j), (j == 3) ? 1 : 0);
    end
    check("bp_resume_gap", lgc(b+2) - lgc(b+1), 21);

    // Watchdog on owner 1
    a = ab_cyc.size(); g = gl_val.size();
    en[0] = 1'b0; en[3] = 1'b0;
    push(1, 1'b0, 8'hD0); push(1, 1'b0, 8'hD1); push(1, 1'b1, 8'hD2);
    push(0, 1'b1, 8'hE0); push(3, 1'b1, 8'hF0);
    refresh();
    n = 0;
    while (q[1].size() > 2 && n < 30) begin step(); n++; end
    check("wd_reach", q[1].size(), 2);
    en[1] = 1'b0; en[0] = 1'b1; en[3] = 1'b1;
    refresh();
    drop = cyc;
    n = 0;
    while (ab_cyc.size() == a && n < 40) begin step(); n++; end
    check("wd_abort_seen", ab_cyc.size() - a, 1);
    check("wd_delay", (a < ab_cyc.size()) ? ab_cyc[a] - drop : -1, 16);
    check("wd_grant_at_abort", (a < ab_grant.size()) ? int'(ab_grant[a]) : -1, 0);
    check("wd_abort_count", (a < ab_cnt.size()) ? ab_cnt[a] : -1, 1);
    drain("wd_drain");
    check("wd_abort_once", ab_cyc.size() - a, 1);
    check("wd_g0", glv(g), 2);
    check("wd_next_from_2", glv(g+1), 8);
    check("wd_then_0", glv(g+2), 1);
    en[1] = 1'b1;
    refresh();
    drain("wd_resume");
    check("wd_src1_again", glv(g+3), 2);
    check("wd_pkts", int'(pkt_count), 8 + 1 + 2 + 1);

    // Lock: source 3 arrives mid-packet of owner 0
    b = lg_data.size(); g = gl_val.size();
    en[3] = 1'b0;
    for (int j = 0; j < 4; j++) push(0, (j == 3), 8'(8'h70 + j));
    push(3, 1'b0, 8'h80); push(3, 1'b1, 8'h81);
    refresh();
    n = 0;
    while (q[0].size() > 3 && n < 30) begin step(); n++; end
    en[3] = 1'b1;
    refresh();
    drain("lock_drain");
    for (int j = 0; j < 4; j++) check("lock_src0", lgd(b+j), 8'h70 + j);
    check("lock_src3_a", lgd(b+4), 8'h80);
    check("lock_src3_b", lgd(b+5), 8'h81);
    check("lock_bubble", lgc(b+4) - lgc(b+3), 2);
    check("lock_g0", glv(g), 1);
    check("lock_g1", glv(g+1), 8);

    // Reset while owner 3 is at beat 2
    for (int j = 0; j < 4; j++) push(3, (j == 3), 8'(8'h90 + j));
    refresh();
    n = 0;
    while (q[3].size() > 3 && n < 30) begin step(); n++; end
    rst_n = 1'b0;
    step();
    check("rst2_no_pop", q[3].size(), 3);
    check("rst2_grant", int'(grant), 0);
    check("rst2_out_valid", int'(bus.out_valid), 0);
    check("rst2_pkt_count", int'(pkt_count), 0);
    check("rst2_abort_count", int'(abort_count), 0);
    rst_n = 1'b1;
    g = gl_val.size();
    push(0, 1'b1, 8'h5A);
    refresh();
    drain("rst2_drain");
    check("rst2_first_grant", glv(g), 1);
    check("rst2_second_grant", glv(g+1), 8);
    check("rst2_pkts", int'(pkt_count), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL global_timeout: got running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
